// File: rtl/adder_pkg.sv
// Shared types and saturation helpers for the serial-adder result collector.
package adder_pkg;

    localparam int ADD_W = 64;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic             cout;
        logic             ovf;
    } add_result_t;

    // Most positive w-bit two's-complement value, zero-extended to ADD_W
    function automatic logic [ADD_W-1:0] sat_max(input int w);
        logic [ADD_W-1:0] v;
        v = '0;
        for (int i = 0; i < ADD_W; i++) begin
            if (i < w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [ADD_W-1:0] sat_min(input int w);
        logic [ADD_W-1:0] v;
        v = '0;
        for (int i = 0; i < ADD_W; i++) begin
            if (i == w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with arbitrary (non power-of-2) depth.
module sync_fifo
    import adder_pkg::*;
#(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_push,
    input  T              i_wdata,
    input  logic          i_pop,
    output T              o_rdata,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    // A full FIFO can still take a write when the head leaves this cycle
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) r_rd <= nxt(r_rd);
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overrun: assert property (
        @(posedge clk) disable iff (!arst_n)
        !(i_push && w_full && !w_pop)
    );

endmodule

// File: rtl/adder_result_collector.sv
// Collects sums from the non-stallable serial adder: tracks live slots,
// flags/saturates signed overflow and buffers results under credit control.
module adder_result_collector
    import adder_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int LATENCY  = WIDTH,
    parameter int DEPTH    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_a_msb,
    input  logic             issue_b_msb,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADD_W-1:0] SMAX_F = sat_max(WIDTH);
    localparam logic [ADD_W-1:0] SMIN_F = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SMAX   = SMAX_F[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN   = SMIN_F[WIDTH-1:0];

    typedef struct packed {
        logic vld;
        logic a_msb;
        logic b_msb;
    } dl_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    dl_t              r_dl [LATENCY];
    dl_t              w_tail;
    logic             w_acc;
    logic             w_push;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    w_count;
    logic [CW:0]      w_used;
    res_t             w_wdata;
    res_t             w_rdata;

    assign w_acc  = issue_valid && issue_ready;
    assign w_tail = r_dl[LATENCY-1];
    assign w_push = w_tail.vld;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < LATENCY; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= {w_acc, issue_a_msb, issue_b_msb};
            for (int i = 1; i < LATENCY; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    assign w_ovf = (w_tail.a_msb == w_tail.b_msb)
                && (add_sum[WIDTH-1] != w_tail.a_msb);

    always_comb begin
        w_sum = add_sum;
        if (SATURATE && w_ovf) w_sum = w_tail.a_msb ? SMIN : SMAX;
    end

    assign w_wdata = '{sum: w_sum, cout: add_cout, ovf: w_ovf};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_acc) - CW'(w_push);
        end
    end

    // Credits cover both slots in the adder and entries already buffered
    assign w_used      = {1'b0, r_inflight} + {1'b0, w_count};
    assign issue_ready = (w_used < (CW + 1)'(DEPTH));

    sync_fifo #(
        .T     (res_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (res_ready),
        .o_rdata (w_rdata),
        .o_valid (res_valid),
        .o_count (w_count)
    );

    assign res_sum  = w_rdata.sum;
    assign res_cout = w_rdata.cout;
    assign res_ovf  = w_rdata.ovf;

endmodule
